// File: rtl/gpr_pkg.sv
// rtl/gpr_pkg.sv - shared types and constants for the GPR write-back path
package gpr_pkg;
  localparam int GPR_AW = 5;
  localparam int GPR_DW = 32;

  typedef logic [GPR_AW-1:0] gpr_addr_t;

  localparam gpr_addr_t          REG_ZERO    = 5'd0;
  localparam gpr_addr_t          REG_OF      = 5'd30;
  localparam logic [GPR_DW-1:0]  OF_FLAG_VAL = 32'd1;

  typedef struct packed {
    gpr_addr_t         addr;
    logic [GPR_DW-1:0] data;
  } wb_req_t;

  localparam int REQ_W = $bits(wb_req_t);
endpackage

// File: rtl/gpr_wb_fifo.sv
// rtl/gpr_wb_fifo.sv - DEPTH-entry synchronous FIFO of write-back requests
// Push when full and pop when empty are ignored; pointers wrap modulo DEPTH (power of 2).
module gpr_wb_fifo
  import gpr_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [REQ_W-1:0]              din,
  input  logic                          pop,
  output logic [REQ_W-1:0]              dout,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(DEPTH+1)-1:0]    count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [REQ_W-1:0] mem_q [DEPTH];
  logic [REQ_W-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push & (count_q != CW'(DEPTH));
    do_pop   = pop & (count_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
endmodule

// File: rtl/gpr_wb_ctrl.sv
// rtl/gpr_wb_ctrl.sv - GPR write-back controller: ALU/LSU merge, overflow flag write, busy scoreboard
// Define GPR_WB_BYPASS_EN to let an LSU word skip an empty FIFO when the ALU is idle.
module gpr_wb_ctrl
  import gpr_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid,
  input  logic [4:0]    alu_waddr,
  input  logic [DW-1:0] alu_wdata,
  input  logic          alu_of,
  input  logic          lsu_valid,
  output logic          lsu_ready,
  input  logic [4:0]    lsu_waddr,
  input  logic [DW-1:0] lsu_wdata,
  input  logic          issue_valid,
  input  logic [4:0]    issue_waddr,
  input  logic [4:0]    rd_addr1,
  input  logic [4:0]    rd_addr2,
  output logic          stall,
  output logic          reg_we,
  output logic [4:0]    reg_waddr,
  output logic [DW-1:0] reg_wdata,
  output logic [31:0]   busy_vec
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          reg_we_q, reg_we_d;
  gpr_addr_t     reg_waddr_q, reg_waddr_d;
  logic [DW-1:0] reg_wdata_q, reg_wdata_d;
  logic [31:0]   busy_q, busy_d;

  logic          lsu_acc, lsu_byp, fifo_push, fifo_pop;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [REQ_W-1:0] fifo_dout;
  wb_req_t       head, lsu_req;
  logic          clr_en;
  gpr_addr_t     clr_addr;

  assign lsu_ready = (fifo_count != CW'(DEPTH)) & ~rst;
  assign lsu_acc   = lsu_valid & lsu_ready;
  assign lsu_req   = '{addr: lsu_waddr, data: lsu_wdata};
  assign head      = wb_req_t'(fifo_dout);

`ifdef GPR_WB_BYPASS_EN
  assign lsu_byp = lsu_acc & fifo_empty & ~alu_valid;
`else
  assign lsu_byp = 1'b0;
`endif

  assign fifo_push = lsu_acc & ~lsu_byp & ~fifo_full;
  assign fifo_pop  = ~alu_valid & ~fifo_empty;

  gpr_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (lsu_req),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    reg_we_d    = 1'b0;
    reg_waddr_d = reg_waddr_q;
    reg_wdata_d = reg_wdata_q;
    clr_en      = 1'b0;
    clr_addr    = REG_ZERO;
    if (alu_valid) begin
      reg_waddr_d = alu_of ? REG_OF : alu_waddr;
      reg_wdata_d = alu_of ? OF_FLAG_VAL : alu_wdata;
      reg_we_d    = (reg_waddr_d != REG_ZERO);
    end else if (fifo_pop) begin
      reg_waddr_d = head.addr;
      reg_wdata_d = head.data;
      reg_we_d    = (head.addr != REG_ZERO);
      clr_en      = 1'b1;
      clr_addr    = head.addr;
    end else if (lsu_byp) begin
      reg_waddr_d = lsu_waddr;
      reg_wdata_d = lsu_wdata;
      reg_we_d    = (lsu_waddr != REG_ZERO);
      clr_en      = 1'b1;
      clr_addr    = lsu_waddr;
    end

    // Clear first so a same-cycle issue to the retiring register stays busy.
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (issue_valid && issue_waddr != REG_ZERO) busy_d[issue_waddr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_we_q    <= 1'b0;
      reg_waddr_q <= REG_ZERO;
      reg_wdata_q <= '0;
      busy_q      <= '0;
    end else begin
      reg_we_q    <= reg_we_d;
      reg_waddr_q <= reg_waddr_d;
      reg_wdata_q <= reg_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign stall     = busy_q[rd_addr1] | busy_q[rd_addr2];
  assign reg_we    = reg_we_q;
  assign reg_waddr = reg_waddr_q;
  assign reg_wdata = reg_wdata_q;
  assign busy_vec  = busy_q;
endmodule

// File: tb/tb_gpr_wb_ctrl.sv
// tb/tb_gpr_wb_ctrl.sv - directed self-checking bench for gpr_wb_ctrl (DEPTH=2, DW=32)
module tb_gpr_wb_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_of, lsu_valid, lsu_ready, issue_valid, stall, reg_we;
  logic [4:0]  alu_waddr, lsu_waddr, issue_waddr, rd_addr1, rd_addr2, reg_waddr;
  logic [31:0] alu_wdata, lsu_wdata, reg_wdata, busy_vec;

  int n_cmp = 0;
  int n_bad = 0;

  gpr_wb_ctrl #(.DEPTH(2), .DW(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_valid   (alu_valid),
    .alu_waddr   (alu_waddr),
    .alu_wdata   (alu_wdata),
    .alu_of      (alu_of),
    .lsu_valid   (lsu_valid),
    .lsu_ready   (lsu_ready),
    .lsu_waddr   (lsu_waddr),
    .lsu_wdata   (lsu_wdata),
    .issue_valid (issue_valid),
    .issue_waddr (issue_waddr),
    .rd_addr1    (rd_addr1),
    .rd_addr2    (rd_addr2),
    .stall       (stall),
    .reg_we      (reg_we),
    .reg_waddr   (reg_waddr),
    .reg_wdata   (reg_wdata),
    .busy_vec    (busy_vec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; alu_valid = 1'b0; alu_of = 1'b0; alu_waddr = '0; alu_wdata = '0;
    lsu_valid = 1'b1; lsu_waddr = 5'd7; lsu_wdata = 32'hDEAD;
    issue_valid = 1'b0; issue_waddr = '0; rd_addr1 = '0; rd_addr2 = '0;

    // reset with an LSU word offered
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_we", {31'd0, reg_we}, 32'd0);
      chk("rst_busy", busy_vec, 32'd0);
      chk("rst_ready", {31'd0, lsu_ready}, 32'd0);
    end
    chk("rst_waddr", {27'd0, reg_waddr}, 32'd0);
    chk("rst_wdata", reg_wdata, 32'd0);
    rst = 1'b0; lsu_valid = 1'b0;
    settle();
    chk("post_rst_ready", {31'd0, lsu_ready}, 32'd1);
    tick();
    chk("post_rst_we", {31'd0, reg_we}, 32'd0);

    // ALU plain write then overflow write
    alu_valid = 1'b1; alu_waddr = 5'd5; alu_wdata = 32'h1234; alu_of = 1'b0;
    tick();
    chk("alu_we", {31'd0, reg_we}, 32'd1);
    chk("alu_waddr", {27'd0, reg_waddr}, 32'd5);
    chk("alu_wdata", reg_wdata, 32'h1234);
    alu_of = 1'b1;
    tick();
    chk("of_we", {31'd0, reg_we}, 32'd1);
    chk("of_waddr", {27'd0, reg_waddr}, 32'd30);
    chk("of_wdata", reg_wdata, 32'd1);
    alu_valid = 1'b0; alu_of = 1'b0;
    tick();
    chk("alu_idle_we", {31'd0, reg_we}, 32'd0);
    chk("alu_no_busy", busy_vec, 32'd0);

    // scoreboard: issue 8, LSU result arrives 3 cycles later
    issue_valid = 1'b1; issue_waddr = 5'd8;
    tick();
    issue_valid = 1'b0; rd_addr1 = 5'd8;
    settle();
    chk("sb_busy8", {31'd0, busy_vec[8]}, 32'd1);
    chk("sb_stall", {31'd0, stall}, 32'd1);
    tick();
    tick();
    lsu_valid = 1'b1; lsu_waddr = 5'd8; lsu_wdata = 32'hAAAA;
    settle();
    chk("sb_ready", {31'd0, lsu_ready}, 32'd1);
    chk("sb_stall_pre", {31'd0, stall}, 32'd1);
    tick();
    lsu_valid = 1'b0;
`ifndef GPR_WB_BYPASS_EN
    settle();
    chk("sb_mid_we", {31'd0, reg_we}, 32'd0);
    chk("sb_mid_busy8", {31'd0, busy_vec[8]}, 32'd1);
    chk("sb_mid_stall", {31'd0, stall}, 32'd1);
    tick();
`endif
    chk("sb_ret_we", {31'd0, reg_we}, 32'd1);
    chk("sb_ret_waddr", {27'd0, reg_waddr}, 32'd8);
    chk("sb_ret_wdata", reg_wdata, 32'hAAAA);
    chk("sb_ret_busy", busy_vec, 32'd0);
    chk("sb_ret_stall", {31'd0, stall}, 32'd0);
    rd_addr1 = '0;
    tick();

    // FIFO fill under continuous ALU traffic, then drain in order
    alu_valid = 1'b1; alu_waddr = 5'd1; alu_wdata = 32'h101;
    lsu_valid = 1'b1; lsu_waddr = 5'd10; lsu_wdata = 32'hA0;
    settle();
    chk("fill_ready0", {31'd0, lsu_ready}, 32'd1);
    tick();
    chk("fill_alu1", {27'd0, reg_waddr}, 32'd1);
    alu_waddr = 5'd2; alu_wdata = 32'h102;
    lsu_waddr = 5'd11; lsu_wdata = 32'hA1;
    settle();
    chk("fill_ready1", {31'd0, lsu_ready}, 32'd1);
    tick();
    chk("fill_alu2", reg_wdata, 32'h102);
    alu_waddr = 5'd3; alu_wdata = 32'h103;
    lsu_waddr = 5'd12; lsu_wdata = 32'hA2;
    settle();
    chk("fill_full", {31'd0, lsu_ready}, 32'd0);
    tick();
    chk("fill_alu3", {27'd0, reg_waddr}, 32'd3);
    chk("fill_still_full", {31'd0, lsu_ready}, 32'd0);
    alu_valid = 1'b0;
    tick();
    chk("drain0_we", {31'd0, reg_we}, 32'd1);
    chk("drain0_waddr", {27'd0, reg_waddr}, 32'd10);
    chk("drain0_wdata", reg_wdata, 32'hA0);
    chk("drain0_ready", {31'd0, lsu_ready}, 32'd1);
    tick();
    lsu_valid = 1'b0;
    chk("drain1_waddr", {27'd0, reg_waddr}, 32'd11);
    chk("drain1_wdata", reg_wdata, 32'hA1);
    chk("drain1_ready", {31'd0, lsu_ready}, 32'd1);
    tick();
    chk("drain2_we", {31'd0, reg_we}, 32'd1);
    chk("drain2_waddr", {27'd0, reg_waddr}, 32'd12);
    chk("drain2_wdata", reg_wdata, 32'hA2);
    tick();
    chk("drain_done_we", {31'd0, reg_we}, 32'd0);

    // writes to $0 are dropped, FIFO still empties
    lsu_valid = 1'b1; lsu_waddr = 5'd0; lsu_wdata = 32'h55;
    tick();
    lsu_valid = 1'b0;
    chk("z_lsu_we_a", {31'd0, reg_we}, 32'd0);
    tick();
    chk("z_lsu_we_b", {31'd0, reg_we}, 32'd0);
    alu_valid = 1'b1; alu_waddr = 5'd0; alu_wdata = 32'h77;
    tick();
    alu_valid = 1'b0;
    chk("z_alu_we", {31'd0, reg_we}, 32'd0);
    chk("z_busy", busy_vec, 32'd0);
    tick();
    chk("z_idle_we", {31'd0, reg_we}, 32'd0);
    // two more words accepted back-to-back proves count returned to 0
    lsu_valid = 1'b1; lsu_waddr = 5'd4; lsu_wdata = 32'h44;
    alu_valid = 1'b1; alu_waddr = 5'd6; alu_wdata = 32'h66;
    tick();
    tick();
    settle();
    chk("z_count0", {31'd0, lsu_ready}, 32'd0);
    lsu_valid = 1'b0; alu_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("z_flush_we", {31'd0, reg_we}, 32'd0);
    chk("z_flush_ready", {31'd0, lsu_ready}, 32'd1);

    // issue to 9 on the same edge the LSU write to 9 retires: set wins
    issue_valid = 1'b1; issue_waddr = 5'd9;
    tick();
    issue_valid = 1'b0;
    chk("sw_busy9_pre", {31'd0, busy_vec[9]}, 32'd1);
    lsu_valid = 1'b1; lsu_waddr = 5'd9; lsu_wdata = 32'h99;
`ifndef GPR_WB_BYPASS_EN
    tick();
    lsu_valid = 1'b0;
`endif
    issue_valid = 1'b1; issue_waddr = 5'd9;
    tick();
    issue_valid = 1'b0; lsu_valid = 1'b0;
    chk("sw_we", {31'd0, reg_we}, 32'd1);
    chk("sw_waddr", {27'd0, reg_waddr}, 32'd9);
    chk("sw_busy9", busy_vec, 32'h200);

    // reset mid-operation flushes queued word and scoreboard
    alu_valid = 1'b1; alu_waddr = 5'd3; alu_wdata = 32'h33;
    lsu_valid = 1'b1; lsu_waddr = 5'd13; lsu_wdata = 32'hD0;
    tick();
    lsu_valid = 1'b0; alu_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_busy", busy_vec, 32'd0);
    chk("mrst_we", {31'd0, reg_we}, 32'd0);
    tick();
    chk("mrst_no_pop_we", {31'd0, reg_we}, 32'd0);
    chk("mrst_waddr", {27'd0, reg_waddr}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
